sdiv_issue_queue: RTL and testbench

- Upstream feeder and result collector for the signed 16-bit iterative divider.
- Buffers dividend/divisor pairs from a valid/ready producer in a small FIFO and issues them one at a time to the divider via go/rdy.
- Resolves divide-by-zero and 0x8000/-1 overflow locally without starting the divider.
- Presents each quotient, with an error code, on a valid/ready output in issue order.

---
 rtl/sdiv_issue_queue_if.sv | 28 ++
 rtl/sdiv_issue_queue.sv | 144 ++++++++++++++
 tb/tb_sdiv_issue_queue.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdiv_issue_queue_if.sv
// Handshake bundle between the divider issue queue and its producer, divider and consumer.
// The slave side is the issue queue; the master side drives operands, divider results and out_ready.
interface sdiv_issue_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic        div_go;
  logic [15:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_rdy;
  logic [15:0] div_quotient;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_quotient;
  logic [1:0]  out_err;
  logic        busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor, div_rdy, div_quotient, out_ready,
    output in_ready, div_go, div_dividend, div_divisor, out_valid, out_quotient, out_err, busy
  );

  modport master (
    output in_valid, in_dividend, in_divisor, div_rdy, div_quotient, out_ready,
    input  in_ready, div_go, div_dividend, div_divisor, out_valid, out_quotient, out_err, busy
  );
endinterface

// File: rtl/sdiv_issue_queue.sv
// Operand FIFO and single-flight issue FSM for the signed 16-bit iterative divider.
// Divide-by-zero and 0x8000/-1 are resolved here; other pairs go to the divider with a timeout guard.
module sdiv_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  sdiv_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_div_a, r_div_b, r_quot;
  logic [1:0]    r_err;

  logic          w_full, w_empty, w_push, w_pop;
  logic          w_ld_res;
  logic [15:0]   w_res_q, w_head_a, w_head_b;
  logic [1:0]    w_res_err;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.in_valid && bus.in_ready;
  assign w_head_a = r_mem[r_rd_ptr][31:16];
  assign w_head_b = r_mem[r_rd_ptr][15:0];

  assign bus.in_ready     = !rst && !w_full;
  assign bus.div_go       = (r_state == ISSUE);
  assign bus.div_dividend = r_div_a;
  assign bus.div_divisor  = r_div_b;
  assign bus.out_valid    = (r_state == HOLD);
  assign bus.out_quotient = r_quot;
  assign bus.out_err      = r_err;
  assign bus.busy         = !w_empty || (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_dividend, bus.in_divisor};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // div_rdy is only honoured in WAIT; a stray or late pulse elsewhere falls through untouched.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_ld_res  = 1'b0;
    w_res_q   = '0;
    w_res_err = 2'b00;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_b == 16'h0000) begin
            w_ld_res  = 1'b1;
            w_res_q   = w_head_a[15] ? 16'h8000 : 16'h7FFF;
            w_res_err = 2'b01;
            w_next    = HOLD;
          end else if (w_head_a == 16'h8000 && w_head_b == 16'hFFFF) begin
            w_ld_res  = 1'b1;
            w_res_q   = 16'h7FFF;
            w_res_err = 2'b10;
            w_next    = HOLD;
          end else begin
            w_next = ISSUE;
          end
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (bus.div_rdy) begin
          w_ld_res  = 1'b1;
          w_res_q   = bus.div_quotient;
          w_res_err = 2'b00;
          w_next    = HOLD;
        end else if (r_tmo == TMO_LAST) begin
          w_ld_res  = 1'b1;
          w_res_q   = 16'h0000;
          w_res_err = 2'b11;
          w_next    = HOLD;
        end
      end
      HOLD: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state == ISSUE) begin
      r_tmo <= '0;
    end else if (r_state == WAIT) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_a <= '0;
      r_div_b <= '0;
      r_quot  <= '0;
      r_err   <= 2'b00;
    end else begin
      if (w_pop) begin
        r_div_a <= w_head_a;
        r_div_b <= w_head_b;
      end
      if (w_ld_res) begin
        r_quot <= w_res_q;
        r_err  <= w_res_err;
      end
    end
  end
endmodule

// File: tb/tb_sdiv_issue_queue.sv
// Scoreboard bench for sdiv_issue_queue with a behavioural divider that answers five cycles after div_go.
// Each operand pair pushed carries a flag saying whether the divider model will answer it.
module tb_sdiv_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdiv_issue_queue_if dif();

  sdiv_issue_queue #(.DEPTH(4), .TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          go_cnt  = 0;
  int          dm_cnt  = 0;
  logic [15:0] dm_q    = '0;
  logic        prev_go = 1'b0;
  logic        inj     = 1'b0;
  logic [17:0] exp_q [$];
  logic [32:0] iss_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic resp);
    logic [15:0] q;
    if (b == 16'h0000) return {(a[15] ? 16'h8000 : 16'h7FFF), 2'b01};
    if (a == 16'h8000 && b == 16'hFFFF) return {16'h7FFF, 2'b10};
    if (!resp) return {16'h0000, 2'b11};
    q = 16'($signed(a) / $signed(b));
    return {q, 2'b00};
  endfunction

  // Divider model plus output scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [17:0] r;
    dif.div_rdy = 1'b0;
    if (rst) begin
      dm_cnt  = 0;
      prev_go = 1'b0;
    end else begin
      if (inj) begin
        dif.div_rdy      = 1'b1;
        dif.div_quotient = 16'h5555;
        inj              = 1'b0;
      end
      if (dif.div_go) begin
        go_cnt++;
        chk("go_gap", 32'(prev_go), 0);
        chk("go_expected", 32'(iss_q.size() != 0), 1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          chk("div_dividend", 32'(dif.div_dividend), 32'(e[31:16]));
          chk("div_divisor", 32'(dif.div_divisor), 32'(e[15:0]));
          if (e[32]) begin
            dm_cnt = 5;
            dm_q   = 16'($signed(e[31:16]) / $signed(e[15:0]));
          end
        end
      end else if (dm_cnt > 0) begin
        dm_cnt--;
        if (dm_cnt == 0) begin
          dif.div_rdy      = 1'b1;
          dif.div_quotient = dm_q;
        end
      end
      prev_go = dif.div_go;
      if (dif.out_valid && dif.out_ready) begin
        chk("out_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("out_quotient", 32'(dif.out_quotient), 32'(r[17:2]));
          chk("out_err", 32'(dif.out_err), 32'(r[1:0]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the cycle after the handshake (or after giving up).
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic resp,
                      input int tries, output bit ok);
    logic [17:0] r;
    dif.in_valid    = 1'b1;
    dif.in_dividend = a;
    dif.in_divisor  = b;
    ok = 1'b0;
    for (int i = 0; i < tries && !ok; i++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        ok = 1'b1;
        r  = model(a, b, resp);
        exp_q.push_back(r);
        if (r[1:0] == 2'b00 || r[1:0] == 2'b11) iss_q.push_back({resp, a, b});
      end
      @(posedge clk);
      #1;
    end
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!dif.div_go && n < 200);
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!dif.out_valid && n < 200);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int n, g0, acc;
    bit ok;
    dif.in_valid     = 1'b0;
    dif.in_dividend  = '0;
    dif.in_divisor   = '0;
    dif.div_rdy      = 1'b0;
    dif.div_quotient = '0;
    dif.out_ready    = 1'b1;

    // reset state, sampled while rst is still high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(dif.in_ready), 0);
    chk("rst_div_go", 32'(dif.div_go), 0);
    chk("rst_div_dividend", 32'(dif.div_dividend), 0);
    chk("rst_div_divisor", 32'(dif.div_divisor), 0);
    chk("rst_out_valid", 32'(dif.out_valid), 0);
    chk("rst_out_quotient", 32'(dif.out_quotient), 0);
    chk("rst_out_err", 32'(dif.out_err), 0);
    chk("rst_busy", 32'(dif.busy), 0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(dif.in_ready), 1);

    // normal divide: 100/7
    step(1);
    g0 = go_cnt;
    push(16'd100, 16'd7, 1'b1, 5, ok);
    chk("t1_accept", 32'(ok), 1);
    wait_go(n);
    chk("t1_go_latency", n, 2);
    chk("t1_div_dividend", 32'(dif.div_dividend), 100);
    chk("t1_div_divisor", 32'(dif.div_divisor), 7);
    wait_ov(n);
    chk("t1_out_latency", n, 6);
    chk("t1_quotient", 32'(dif.out_quotient), 14);
    chk("t1_err", 32'(dif.out_err), 0);
    step(2);
    chk("t1_go_count", go_cnt - g0, 1);
    chk("t1_out_valid_fell", 32'(dif.out_valid), 0);

    // local cases: divide-by-zero both signs and overflow
    g0 = go_cnt;
    push(16'hFF9C, 16'h0000, 1'b1, 5, ok);
    wait_ov(n);
    chk("dz_neg_latency", n, 2);
    chk("dz_neg_quotient", 32'(dif.out_quotient), 32'h8000);
    chk("dz_neg_err", 32'(dif.out_err), 1);
    step(2);
    push(16'd5, 16'h0000, 1'b1, 5, ok);
    wait_ov(n);
    chk("dz_pos_quotient", 32'(dif.out_quotient), 32'h7FFF);
    chk("dz_pos_err", 32'(dif.out_err), 1);
    step(2);
    push(16'h8000, 16'hFFFF, 1'b1, 5, ok);
    wait_ov(n);
    chk("ovf_latency", n, 2);
    chk("ovf_quotient", 32'(dif.out_quotient), 32'h7FFF);
    chk("ovf_err", 32'(dif.out_err), 2);
    step(2);
    chk("local_no_go", go_cnt - g0, 0);

    // backpressure: DEPTH+1 accepted, then released in order
    dif.out_ready = 1'b0;
    g0  = go_cnt;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(16'(i * 37 - 90), (i % 2 == 1) ? 16'(-(i + 2)) : 16'(i + 2), 1'b1, 20, ok);
      acc += int'(ok);
    end
    chk("bp_accepted", acc, 5);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(dif.in_ready), 0);
    chk("bp_busy", 32'(dif.busy), 1);
    step(1);
    dif.out_ready = 1'b1;
    drain("bp_drain");
    step(2);
    chk("bp_go_count", go_cnt - g0, 5);

    // timeout, a stray div_rdy while holding, then a normal op behind it
    dif.out_ready = 1'b0;
    g0 = go_cnt;
    push(16'd50, 16'd5, 1'b0, 5, ok);
    push(16'd60, 16'hFFFD, 1'b1, 5, ok);
    wait_go(n);
    wait_ov(n);
    chk("tmo_latency", n, 41);
    chk("tmo_quotient", 32'(dif.out_quotient), 0);
    chk("tmo_err", 32'(dif.out_err), 3);
    step(1);
    inj = 1'b1;
    step(3);
    chk("tmo_stray_quotient", 32'(dif.out_quotient), 0);
    chk("tmo_stray_err", 32'(dif.out_err), 3);
    chk("tmo_still_valid", 32'(dif.out_valid), 1);
    dif.out_ready = 1'b1;
    drain("tmo_drain");
    step(2);
    chk("tmo_go_count", go_cnt - g0, 2);

    // reset during WAIT with three entries queued
    push(16'd7, 16'd1, 1'b0, 5, ok);
    push(16'd8, 16'd2, 1'b1, 5, ok);
    push(16'd9, 16'd3, 1'b1, 5, ok);
    push(16'd10, 16'd5, 1'b1, 5, ok);
    step(2);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    step(1);
    rst = 1'b0;
    g0 = go_cnt;
    @(negedge clk);
    chk("mrst_out_valid", 32'(dif.out_valid), 0);
    chk("mrst_busy", 32'(dif.busy), 0);
    chk("mrst_in_ready", 32'(dif.in_ready), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mrst_no_go", 32'(dif.div_go), 0);
    end
    step(10);
    chk("mrst_go_count", go_cnt - g0, 0);

    // recovery after reset
    push(16'hFFB3, 16'd7, 1'b1, 5, ok);
    wait_ov(n);
    chk("rec_quotient", 32'(dif.out_quotient), 32'hFFF5);
    drain("rec_drain");
    step(2);
    chk("final_busy", 32'(dif.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
